// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
// The search is written for up to MAX_REQ requesters so it can be reused by other schedulers.
package fifo_arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_e;

  localparam int MAX_REQ = 8;

  // Returns the first set request strictly after 'last', wrapping modulo num_req; -1 if none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int num_req);
    int pick;
    int idx;
    pick = -1;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = last + k;
        if (idx >= num_req) idx = idx - num_req;
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority selector: lowest index after last_owner wins.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic               pick_vld,
  output logic [ID_W-1:0]    pick_id
);

  logic [MAX_REQ-1:0] req_pad;
  int                 pick;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    pick = rr_pick(req_pad, int'(last_owner), NUM_REQ);
    pick_vld = (pick >= 0);
    pick_id = pick_vld ? ID_W'(pick) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of a single FIFO write port between NUM_REQ producers.
// Every grant spends one IDLE cycle arbitrating before its first beat can be written.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic                     grant_vld,
  output logic [ID_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  arb_state_e       state, state_d;
  logic [ID_W-1:0]  owner, owner_d;
  logic [ID_W-1:0]  last_owner, last_owner_d;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_d;
  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic             owner_vld;
  logic             accept;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (req_valid),
    .last_owner(last_owner),
    .pick_vld  (pick_vld),
    .pick_id   (pick_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_ID;
      beat_cnt   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      beat_cnt   <= beat_cnt_d;
    end
  end

  // Write strobes are also gated by rst_n so a reset edge landing mid-burst never commits a beat.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    beat_cnt_d   = beat_cnt;
    owner_vld    = req_valid[owner];
    accept       = 1'b0;
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d    = OWN;
          owner_d    = pick_id;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        req_ready[owner] = rst_n & ~fifo_full;
        accept           = rst_n & owner_vld & ~fifo_full;
        fifo_w_en        = accept;
        fifo_data_in     = req_data[int'(owner)*WIDTH +: WIDTH];
        if (!owner_vld) begin
          state_d      = IDLE;
          last_owner_d = owner;
        end else if (accept) begin
          if (beat_cnt == LAST_BEAT) begin
            state_d      = IDLE;
            last_owner_d = owner;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_vld = (state == OWN);
  assign grant_id  = grant_vld ? owner : '0;

endmodule
